// File: rtl/if_prefetch_unit.sv
// LC-3 instruction-fetch stage with a DEPTH-entry prefetch buffer.
// Fetches ahead over a req/gnt/rvalid port, tags each returned word with its PC,
// and drops responses that belong to requests issued before a redirect.
module if_prefetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h3000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_ir,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_npc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] respPc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  discardNext;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [DATA_W-1:0] bufIr [DEPTH];
    logic [ADDR_W-1:0] bufPc [DEPTH];

    logic              issue;
    logic              grant;
    logic              push;
    logic              drop;
    logic              pop;
    logic              headValid;
    logic [SUM_W-1:0]  credit;
    logic [SUM_W-1:0]  inflight;

    assign headValid = (count != '0);

    // Next-state, issue/response decisions and discard bookkeeping
    always_comb begin
        stateNext   = state;
        issue       = 1'b0;
        grant       = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        pop         = 1'b0;
        discardNext = discard;
        inflight    = '0;
        credit      = SUM_W'(outstanding) + SUM_W'(count);

        // A redirect overrides every other action in its cycle
        drop  = mem_rvalid && (discard != '0) && !redirect_valid;
        push  = mem_rvalid && (discard == '0) && (outstanding != '0) && !redirect_valid;
        pop   = headValid && !stall && !redirect_valid;
        issue = (state == FETCH) && !redirect_valid && (credit < DEPTH_S);
        grant = issue && mem_gnt;

        // Requests still in flight at a redirect become stale and must be dropped on return
        if (redirect_valid) begin
            inflight = SUM_W'(discard) + SUM_W'(outstanding);
            if (mem_rvalid && (inflight != '0)) begin
                inflight = inflight - SUM_W'(1);
            end
            discardNext = CNT_W'(inflight);
        end else if (drop) begin
            discardNext = discard - CNT_W'(1);
        end

        case (state)
            BOOT: begin
                stateNext = FETCH;
            end
            FETCH: begin
                if (redirect_valid && (discardNext != '0)) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (discardNext == '0) begin
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    // FSM state and stale-response counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= BOOT;
            discard <= '0;
        end else begin
            state   <= stateNext;
            discard <= discardNext;
        end
    end

    // Fetch pointer, response tag, credit counters and buffer pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else if (redirect_valid) begin
            fetchPc     <= redirect_pc;
            respPc      <= redirect_pc;
            outstanding <= '0;
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else begin
            if (grant) begin
                fetchPc <= fetchPc + ADDR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(push);
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wrPtr  <= wrPtr + PTR_W'(1);
                respPc <= respPc + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    // Buffer storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            bufIr[wrPtr] <= mem_rdata;
            bufPc[wrPtr] <= respPc;
        end
    end

    assign mem_req  = issue;
    assign mem_addr = (state == BOOT) ? '0 : fetchPc;
    assign if_valid = headValid;
    assign if_ir    = headValid ? bufIr[rdPtr] : '0;
    assign if_pc    = headValid ? bufPc[rdPtr] : '0;
    assign if_npc   = headValid ? (bufPc[rdPtr] + ADDR_W'(1)) : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Testbench for if_prefetch_unit: directed vector table, corner sequences and
// randomized traffic checked against an epoch-tagged request/buffer queue model.
module tb_if_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic [15:0] if_npc;

    if_prefetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .if_npc         (if_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          ep;
        int          due;
    } req_t;

    typedef struct {
        bit          rst;
        bit          st;
        bit          eReq;
        logic [15:0] eAddr;
        bit          eValid;
        logic [15:0] ePc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    bit          boot = 1'b1;
    logic [15:0] expPc = 16'h3000;
    req_t        memQ[$];
    logic [15:0] bufQ[$];
    int          latMin = 1;
    int          latMax = 1;
    int          rvProb = 100;

    logic        lastReq;
    logic [15:0] lastAddr;
    logic        lastValid;
    logic [15:0] lastPc;
    logic [15:0] lastNpc;
    logic [15:0] lastIr;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[3:0], a[15:4]} ^ 16'h9E37;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic chkZero(input string nm);
        chk({nm, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({nm, "_if_ir"}, 32'(if_ir), 32'd0);
        chk({nm, "_if_pc"}, 32'(if_pc), 32'd0);
        chk({nm, "_if_npc"}, 32'(if_npc), 32'd0);
    endtask

    task automatic clearModel();
        memQ.delete();
        bufQ.delete();
        epoch  = 0;
        expPc  = 16'h3000;
        boot   = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 16'h0;
        clearModel();
        @(negedge clk);
        chkZero("rst");
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // One clock: check outputs, drive inputs, check request, advance the model
    task automatic step(input bit st, input bit rd, input logic [15:0] rpc, input bit g, input bit stray);
        bit   expReq;
        bit   rvHit;
        bit   popOk;
        int   stale;
        int   lat;
        req_t h;
        @(negedge clk);
        lastValid = if_valid;
        lastPc    = if_pc;
        lastNpc   = if_npc;
        lastIr    = if_ir;
        chk("if_valid", 32'(if_valid), 32'(bufQ.size() != 0));
        if (bufQ.size() != 0) begin
            chk("if_pc", 32'(if_pc), 32'(bufQ[0]));
            chk("if_npc", 32'(if_npc), 32'(16'(bufQ[0] + 16'd1)));
            chk("if_ir", 32'(if_ir), 32'(memWord(bufQ[0])));
        end
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        mem_gnt        = g;
        rvHit          = 1'b0;
        if (memQ.size() != 0 && memQ[0].due <= cyc && int'($urandom_range(99)) < rvProb) begin
            rvHit = 1'b1;
        end
        if (rvHit) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memWord(memQ[0].addr);
        end else if (stray && memQ.size() == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hDEAD;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        #1;
        stale = 0;
        foreach (memQ[i]) if (memQ[i].ep != epoch) stale++;
        expReq   = !boot && !rd && (stale == 0) && ((memQ.size() + bufQ.size()) < 4);
        lastReq  = mem_req;
        lastAddr = mem_addr;
        chk("mem_req", 32'(mem_req), 32'(expReq));
        if (expReq) chk("mem_addr", 32'(mem_addr), 32'(expPc));
        popOk = (bufQ.size() != 0) && !st;
        if (rd) begin
            bufQ.delete();
            if (rvHit) void'(memQ.pop_front());
            epoch++;
            expPc = rpc;
        end else begin
            if (popOk) void'(bufQ.pop_front());
            if (rvHit) begin
                h = memQ.pop_front();
                if (h.ep == epoch) bufQ.push_back(h.addr);
            end
            if (expReq && g) begin
                lat = int'($urandom_range(latMax, latMin));
                memQ.push_back('{expPc, epoch, cyc + lat});
                expPc = expPc + 16'd1;
            end
        end
        boot = 1'b0;
        cyc++;
    endtask

    vec_t        tbl[17];
    bit          found;
    bit          rdR;
    logic [15:0] rpcR;

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 16'h0;

        // Streaming after reset, then back-pressure from the first cycle
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h3001, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h3002, 1'b1, 16'h3000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h3003, 1'b1, 16'h3001};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h3004, 1'b1, 16'h3002};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h3000, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h3001, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h3002, 1'b1, 16'h3000};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h3003, 1'b1, 16'h3000};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3000};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3000};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 16'h3004, 1'b1, 16'h3001};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 16'h3005, 1'b1, 16'h3002};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 16'h3006, 1'b1, 16'h3003};

        latMin = 1; latMax = 1; rvProb = 100;
        foreach (tbl[i]) begin
            if (tbl[i].rst) doReset();
            step(tbl[i].st, 1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_req", i), 32'(lastReq), 32'(tbl[i].eReq));
            if (tbl[i].eReq) chk($sformatf("tbl%0d_addr", i), 32'(lastAddr), 32'(tbl[i].eAddr));
            chk($sformatf("tbl%0d_valid", i), 32'(lastValid), 32'(tbl[i].eValid));
            if (tbl[i].eValid) chk($sformatf("tbl%0d_pc", i), 32'(lastPc), 32'(tbl[i].ePc));
        end

        // Redirect with two requests in flight at latency 3
        doReset();
        latMin = 3; latMax = 3;
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h4000, 1'b1, 1'b0);
        chk("t3_req_at_redirect", 32'(lastReq), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            if (lastValid) begin
                found = 1'b1;
                chk("t3_first_pc", 32'(lastPc), 32'h4000);
            end
        end
        chk("t3_valid_seen", 32'(found), 32'd1);

        // PC wrap at the top of memory
        latMin = 1; latMax = 1;
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            if (lastValid) begin
                found = 1'b1;
                chk("t4_pc", 32'(lastPc), 32'hFFFF);
                chk("t4_npc", 32'(lastNpc), 32'h0000);
            end
        end
        chk("t4_valid_seen", 32'(found), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t4_next_valid", 32'(lastValid), 32'd1);
        chk("t4_next_pc", 32'(lastPc), 32'h0000);

        // Request held while the grant is withheld
        step(1'b0, 1'b1, 16'h5000, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            if (lastReq) found = 1'b1;
        end
        chk("t5_req_seen", 32'(found), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            chk("t5_hold_req", 32'(lastReq), 32'd1);
            chk("t5_hold_addr", 32'(lastAddr), 32'h5000);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t5_grant_addr", 32'(lastAddr), 32'h5000);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t5_after_addr", 32'(lastAddr), 32'h5001);

        // Randomized traffic
        latMin = 1; latMax = 4; rvProb = 75;
        for (int k = 0; k < 1500; k++) begin
            rdR  = ($urandom_range(99) < 4);
            rpcR = ($urandom_range(1) == 1) ? 16'($urandom_range(16'hFFFF, 16'hFFF8)) : 16'($urandom);
            step($urandom_range(99) < 30, rdR, rpcR, $urandom_range(99) < 70, 1'b0);
        end

        // Reset with a full buffer, then a stray response after release
        latMin = 1; latMax = 1; rvProb = 100;
        doReset();
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_full_valid", 32'(lastValid), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        stall      = 1'b0;
        mem_rvalid = 1'b0;
        #1 chkZero("t6_async");
        clearModel();
        @(posedge clk);
        #2 reset = 1'b1;
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("t6_first_addr", 32'(lastAddr), 32'h3000);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            if (lastValid) begin
                found = 1'b1;
                chk("t6_first_pc", 32'(lastPc), 32'h3000);
                chk("t6_first_ir", 32'(lastIr), 32'(memWord(16'h3000)));
            end
        end
        chk("t6_valid_seen", 32'(found), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
